sdram_write: RTL and testbench

//  Write-burst engine feeding the SDRAM arbiter's WRITE path.
//  - Once the arbiter grants wr_en, runs one burst: ACTIVE, tRCD wait, WRITE, data beats, BURST STOP, tWR wait,

---
 rtl/sdram_pkg.sv | 52 +++++
 rtl/sdram_write.sv | 106 ++++++++++
 tb/tb_sdram_write.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, write-engine states and
// field slices of the 24-bit {bank, row, column} address.
package sdram_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned BA_W   = 2;
  localparam int unsigned ROW_W  = 13;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned LEN_W  = 10;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 10;

  localparam int unsigned BA_LSB  = ROW_W + COL_W;
  localparam int unsigned ROW_LSB = COL_W;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP    = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_ACTIVE = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WRITE  = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_BSTOP  = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_PRECH  = 4'b0010;

  localparam logic [BA_W-1:0]  BA_IDLE        = 2'b11;
  localparam logic [ROW_W-1:0] ADDR_IDLE      = 13'h1fff;
  localparam logic [ROW_W-1:0] ADDR_PRECH_ALL = 13'h0400;

  typedef enum logic [3:0] {
    WR_IDLE  = 4'd0,
    WR_ACT   = 4'd1,
    WR_TRCD  = 4'd2,
    WR_WRITE = 4'd3,
    WR_DATA  = 4'd4,
    WR_TWR   = 4'd5,
    WR_PRE   = 4'd6,
    WR_TRP   = 4'd7,
    WR_END   = 4'd8
  } wr_state_e;

  function automatic logic [BA_W-1:0] wa_ba(input logic [ADDR_W-1:0] a);
    return a[BA_LSB +: BA_W];
  endfunction

  function automatic logic [ROW_W-1:0] wa_row(input logic [ADDR_W-1:0] a);
    return a[ROW_LSB +: ROW_W];
  endfunction

  function automatic logic [COL_W-1:0] wa_col(input logic [ADDR_W-1:0] a);
    return a[COL_W-1:0];
  endfunction

endpackage

// File: rtl/sdram_write.sv
// SDRAM write-burst engine: ACTIVE, tRCD, WRITE + data beats, BURST STOP, tWR,
// PRECHARGE-all, tRP, then a one-cycle wr_end back to the arbiter.
module sdram_write
  import sdram_pkg::*;
#(
  parameter int unsigned TRCD_CLK = 2,
  parameter int unsigned TWR_CLK  = 2,
  parameter int unsigned TRP_CLK  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [LEN_W-1:0]  wr_burst_len_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  output logic              wr_end_o,
  output logic [CMD_W-1:0]  write_cmd_o,
  output logic [BA_W-1:0]   write_ba_o,
  output logic [ROW_W-1:0]  write_addr_o,
  output logic              wr_sdram_en_o,
  output logic [DATA_W-1:0] wr_sdram_data_o
);

  wr_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              start;

  assign start = (state_q == WR_IDLE) && init_end_i && wr_en_i;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= WR_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  // Next state; the request is captured only on the grant edge so later input changes are ignored
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    unique case (state_q)
      WR_IDLE: begin
        if (start) begin
          state_d = WR_ACT;
          addr_d  = wr_addr_i;
          len_d   = (wr_burst_len_i == '0) ? LEN_W'(1) : wr_burst_len_i;
        end
      end
      WR_ACT:   state_d = WR_TRCD;
      WR_TRCD:  if (cnt_q == CNT_W'(TRCD_CLK - 1)) state_d = WR_WRITE;
      WR_WRITE: state_d = (len_q > LEN_W'(1)) ? WR_DATA : WR_TWR;
      WR_DATA:  if (cnt_q == CNT_W'(len_q - LEN_W'(2))) state_d = WR_TWR;
      WR_TWR:   if (cnt_q == CNT_W'(TWR_CLK - 1)) state_d = WR_PRE;
      WR_PRE:   state_d = WR_TRP;
      WR_TRP:   if (cnt_q == CNT_W'(TRP_CLK - 1)) state_d = WR_END;
      WR_END:   state_d = WR_IDLE;
      default:  state_d = WR_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Command/address bus and beat strobes decoded straight from state and counter
  always_comb begin
    write_cmd_o     = CMD_NOP;
    write_ba_o      = BA_IDLE;
    write_addr_o    = ADDR_IDLE;
    wr_ack_o        = 1'b0;
    wr_end_o        = 1'b0;
    unique case (state_q)
      WR_ACT: begin
        write_cmd_o  = CMD_ACTIVE;
        write_ba_o   = wa_ba(addr_q);
        write_addr_o = wa_row(addr_q);
      end
      WR_WRITE: begin
        write_cmd_o  = CMD_WRITE;
        write_ba_o   = wa_ba(addr_q);
        write_addr_o = {(ROW_W - COL_W)'(0), wa_col(addr_q)};
        wr_ack_o     = 1'b1;
      end
      WR_DATA:  wr_ack_o = 1'b1;
      WR_TWR:   if (cnt_q == '0) write_cmd_o = CMD_BSTOP;
      WR_PRE: begin
        write_cmd_o  = CMD_PRECH;
        write_addr_o = ADDR_PRECH_ALL;
      end
      WR_END:   wr_end_o = 1'b1;
      default: ;
    endcase
    wr_sdram_en_o   = wr_ack_o;
    wr_sdram_data_o = wr_ack_o ? wr_data_i : '0;
  end

endmodule

// File: tb/tb_sdram_write.sv
// Scoreboard bench for sdram_write: stimulus queues the expected command/beat
// events with their cycle numbers; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sdram_write;
  import sdram_pkg::*;

  localparam int unsigned TRCD = 2;
  localparam int unsigned TWR  = 2;
  localparam int unsigned TRP  = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        wr_en = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [9:0]  wr_len = '0;
  logic [15:0] wr_data;
  logic        wr_ack, wr_end, wr_sdram_en;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [15:0] sdram_data;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        ack;
    logic        en;
    logic [15:0] data;
    logic        fin;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] fifo_mem [1024];
  logic [9:0]  rd_ptr = '0;

  always #5 sys_clk = ~sys_clk;

  // Show-ahead FIFO model: head word presented, popped on each acked beat
  assign wr_data = fifo_mem[rd_ptr];
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (wr_ack) rd_ptr <= rd_ptr + 10'd1;
  end

  sdram_write #(.TRCD_CLK(TRCD), .TWR_CLK(TWR), .TRP_CLK(TRP)) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .init_end_i      (init_end),
    .wr_en_i         (wr_en),
    .wr_addr_i       (wr_addr),
    .wr_burst_len_i  (wr_len),
    .wr_data_i       (wr_data),
    .wr_ack_o        (wr_ack),
    .wr_end_o        (wr_end),
    .write_cmd_o     (cmd),
    .write_ba_o      (ba),
    .write_addr_o    (addr),
    .wr_sdram_en_o   (wr_sdram_en),
    .wr_sdram_data_o (sdram_data)
  );

  function automatic ev_t mk_ev(input int c, input logic [3:0] k, input logic [1:0] b,
                                input logic [12:0] a, input logic ack, input logic [15:0] d,
                                input logic fin);
    ev_t e;
    e.cyc = 32'(c); e.cmd = k; e.ba = b; e.addr = a;
    e.ack = ack; e.en = ack; e.data = d; e.fin = fin;
    return e;
  endfunction

  // Bank/address only matter on ACTIVE and WRITE; address also on PRECHARGE
  function automatic bit ev_match(input ev_t a, input ev_t e);
    bit ok;
    ok = (a.cyc == e.cyc) && (a.cmd == e.cmd) && (a.ack == e.ack) && (a.en == e.en) &&
         (a.data == e.data) && (a.fin == e.fin);
    if (e.cmd == CMD_ACTIVE || e.cmd == CMD_WRITE) ok = ok && (a.ba == e.ba) && (a.addr == e.addr);
    if (e.cmd == CMD_PRECH) ok = ok && (a.addr == e.addr);
    return ok;
  endfunction

  always @(negedge sys_clk) begin : monitor
    ev_t act, ex;
    act = mk_ev(cyc, cmd, ba, addr, wr_ack, sdram_data, wr_end);
    act.en = wr_sdram_en;
    if (cmd != CMD_NOP || wr_ack || wr_end || wr_sdram_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d cmd=%b ack=%b end=%b (no event expected)",
                 cyc, cmd, wr_ack, wr_end);
      end else begin
        ex = exp_q.pop_front();
        if (!ev_match(act, ex))
          begin
            n_fail++;
            $display("FAIL event got cyc=%0d cmd=%b ba=%0d addr=%h ack=%b en=%b data=%h end=%b, want cyc=%0d cmd=%b ba=%0d addr=%h ack=%b data=%h end=%b",
                     act.cyc, act.cmd, act.ba, act.addr, act.ack, act.en, act.data, act.fin,
                     ex.cyc, ex.cmd, ex.ba, ex.addr, ex.ack, ex.data, ex.fin);
          end
      end
    end else begin
      n_checks++;
      if (sdram_data !== 16'h0) begin
        n_fail++;
        $display("FAIL idle_data cyc=%0d got %h want 0000", cyc, sdram_data);
      end
    end
  end

  task automatic check_vec(input string name, input logic [37:0] got, input logic [37:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [37:0] out_vec();
    return {cmd, ba, addr, wr_ack, wr_sdram_en, sdram_data, wr_end};
  endfunction

  localparam logic [37:0] IDLE_VEC = {4'b0111, 2'b11, 13'h1fff, 1'b0, 1'b0, 16'h0000, 1'b0};

  // One full burst: queue its expected events, grant, then drop grant on wr_end
  task automatic run_burst(input logic [23:0] a, input logic [9:0] len, input logic [15:0] seed,
                           input logic [1:0] eba, input logic [12:0] erow, input logic [8:0] ecol,
                           input int unsigned elen, input bit scramble);
    int c0, cw, k;
    @(negedge sys_clk);
    for (int i = 0; i < int'(elen); i++) fifo_mem[rd_ptr + 10'(i)] = seed + 16'(i);
    c0 = cyc;
    cw = c0 + 2 + int'(TRCD);
    exp_q.push_back(mk_ev(c0 + 1, CMD_ACTIVE, eba, erow, 1'b0, 16'h0, 1'b0));
    exp_q.push_back(mk_ev(cw, CMD_WRITE, eba, {4'b0, ecol}, 1'b1, seed, 1'b0));
    for (int i = 1; i < int'(elen); i++)
      exp_q.push_back(mk_ev(cw + i, CMD_NOP, 2'b0, 13'h0, 1'b1, seed + 16'(i), 1'b0));
    exp_q.push_back(mk_ev(cw + int'(elen), CMD_BSTOP, 2'b0, 13'h0, 1'b0, 16'h0, 1'b0));
    exp_q.push_back(mk_ev(cw + int'(elen) + int'(TWR), CMD_PRECH, 2'b0, 13'h0400, 1'b0, 16'h0, 1'b0));
    exp_q.push_back(mk_ev(cw + int'(elen) + int'(TWR) + 1 + int'(TRP), CMD_NOP, 2'b0, 13'h0,
                          1'b0, 16'h0, 1'b1));
    wr_addr = a;
    wr_len  = len;
    wr_en   = 1'b1;
    @(negedge sys_clk);
    if (scramble) begin
      wr_addr = ~a;
      wr_len  = 10'd7;
    end
    for (k = 0; k < 2000 && !wr_end; k++) @(negedge sys_clk);
    n_checks++;
    if (!wr_end) begin
      n_fail++;
      $display("FAIL wr_end_timeout got no wr_end within %0d cycles want wr_end", k);
    end
    wr_en = 1'b0;
  endtask

  initial begin : stim
    logic [9:0] p0;
    int cw, k;
    for (int i = 0; i < 1024; i++) fifo_mem[i] = 16'h0;

    // Reset state, then no burst while init_end is low
    #12;
    check_vec("reset_outputs", out_vec(), IDLE_VEC);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wr_addr = 24'h40_0A05; wr_len = 10'd4; wr_en = 1'b1;
    repeat (20) @(negedge sys_clk);
    check_vec("no_init_idle", out_vec(), IDLE_VEC);
    wr_en = 1'b0;
    init_end = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Basic 4-beat burst; request inputs changed after grant must be ignored
    run_burst(24'h40_0A05, 10'd4, 16'hD000, 2'd1, 13'h0005, 9'h005, 4, 1'b1);
    repeat (3) @(negedge sys_clk);

    // Single beat, top corner address
    run_burst(24'hFF_FFFF, 10'd1, 16'h1111, 2'd3, 13'h1fff, 9'h1ff, 1, 1'b0);
    repeat (3) @(negedge sys_clk);

    // Zero length behaves as one beat
    run_burst(24'h00_0000, 10'd0, 16'h2222, 2'd0, 13'h0000, 9'h000, 1, 1'b0);
    repeat (3) @(negedge sys_clk);

    // Full-page burst: 512 beats, 512 FIFO words consumed
    p0 = rd_ptr;
    run_burst(24'h82_4600, 10'd512, 16'h8000, 2'd2, 13'h0123, 9'h000, 512, 1'b0);
    repeat (2) @(negedge sys_clk);
    check_vec("fifo_words_512", 38'(10'(rd_ptr - p0)), 38'(10'd512));
    repeat (2) @(negedge sys_clk);

    // Reset during the third beat (second DATA cycle)
    @(negedge sys_clk);
    for (int i = 0; i < 4; i++) fifo_mem[rd_ptr + 10'(i)] = 16'h5000 + 16'(i);
    cw = cyc + 2 + int'(TRCD);
    exp_q.push_back(mk_ev(cyc + 1, CMD_ACTIVE, 2'd1, 13'h0005, 1'b0, 16'h0, 1'b0));
    exp_q.push_back(mk_ev(cw, CMD_WRITE, 2'd1, 13'h0005, 1'b1, 16'h5000, 1'b0));
    exp_q.push_back(mk_ev(cw + 1, CMD_NOP, 2'd0, 13'h0, 1'b1, 16'h5001, 1'b0));
    wr_addr = 24'h40_0A05; wr_len = 10'd4; wr_en = 1'b1;
    for (k = 0; k < 100 && cyc < cw + 1; k++) @(negedge sys_clk);
    @(posedge sys_clk);
    #2;
    check_vec("beat2_before_reset", {35'h0, wr_ack, wr_sdram_en, wr_end}, {35'h0, 1'b1, 1'b1, 1'b0});
    sys_rst_n = 1'b0;
    wr_en = 1'b0;
    #1;
    check_vec("reset_async", out_vec(), IDLE_VEC);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_vec("post_reset_idle", out_vec(), IDLE_VEC);
    run_burst(24'hC0_0201, 10'd2, 16'h6000, 2'd3, 13'h0001, 9'h001, 2, 1'b0);
    repeat (3) @(negedge sys_clk);

    // Back-to-back grants: arbiter re-grants one cycle after dropping wr_en
    run_burst(24'h7F_C1FF, 10'd8, 16'h7000, 2'd1, 13'h1FE0, 9'h1ff, 8, 1'b0);
    run_burst(24'h00_0210, 10'd3, 16'h9000, 2'd0, 13'h0001, 9'h010, 3, 1'b0);
    repeat (5) @(negedge sys_clk);

    check_vec("scoreboard_drained", 38'(exp_q.size()), 38'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
